advanced_counter_n: RTL and testbench

Parametrised, cascadable up/down event counter, successor to the fixed 4-bit counter. It counts rising edges of a slow, asynchronous `inc` input using an internal synchroniser and edge detector. It supports a programmable modulo limit, a carry chain for multi-digit counters, synchronous parallel load, and three terminal-count modes: wrap, one-shot and auto-reload. It sits between a front-panel/pulse source and display or compare logic.

---
 rtl/counter_pkg.sv | 13 +
 rtl/inc_edge_sync.sv | 30 +++
 rtl/advanced_counter_n.sv | 99 +++++++++
 tb/tb_advanced_counter_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the advanced event counter: terminal-count modes and FSM states.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_RELOAD  = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/inc_edge_sync.sv
// Synchroniser chain plus rising-edge detector for a slow asynchronous pulse input.
// All flops reset to 1 so a level held through reset never looks like a rising edge.
module inc_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    output logic evt_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '1;
            dly_q  <= 1'b1;
        end else begin
            sync_q[0] <= inc_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[STAGES-1];
        end
    end

    assign evt_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/advanced_counter_n.sv
// Cascadable up/down event counter with modulo limit, parallel load and
// wrap / one-shot / auto-reload terminal-count behaviour.
module advanced_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             up_down_sel,
    input  logic             carry_en,
    input  logic             carry_in,
    input  logic             max_en,
    input  logic [WIDTH-1:0] max_val,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic             carry_out,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit;
    state_e           state_q, state_d;
    logic             evt;
    logic             step;
    logic             terminal;

    inc_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_inc_edge_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (inc),
        .evt_o   (evt)
    );

    always_comb begin
        limit    = max_en ? max_val : '1;
        step     = evt & (carry_en ? carry_in : 1'b1) & (state_q == ST_RUN);
        // Up: anything at or above the limit is terminal, which covers a lowered max_val.
        terminal = up_down_sel ? (cnt_q == '0) : (cnt_q >= limit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (step && terminal && mode == MODE_ONESHOT) state_d = ST_DONE;
                ST_DONE: if (mode != MODE_ONESHOT) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (step) begin
            if (terminal) begin
                case (mode)
                    MODE_RELOAD:  cnt_d = load_val;
                    MODE_ONESHOT: cnt_d = cnt_q;
                    default:      cnt_d = up_down_sel ? limit : '0;
                endcase
            end else if (up_down_sel) begin
                // Down count above a lowered limit snaps to the limit without a carry.
                cnt_d = (cnt_q > limit) ? limit : cnt_q - 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_out   = cnt_q;
        carry_out = step & terminal & ~load;
        tc        = up_down_sel ? (cnt_q == '0) : (cnt_q == limit);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_advanced_counter_n.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_advanced_counter_n;

    logic       clk = 1'b0;
    logic       reset, reset_u;
    logic       inc;
    logic       ud, max_en, load;
    logic [1:0] mode;
    logic [3:0] max_val, load_val;
    logic [3:0] cnt_l, cnt_u;
    logic       carry_l, carry_u, tc_l, tc_u, done_l, done_u;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cyc;
        bit          upper;
        bit          c_cnt, c_car, c_tc, c_dn;
        logic [3:0]  cnt;
        logic        car, tcv, dn;
        string       name;
    } exp_t;

    exp_t q[$];

    advanced_counter_n #(.WIDTH(4), .SYNC_STAGES(2)) u_lo (
        .clk(clk), .reset(reset), .inc(inc), .up_down_sel(ud), .carry_en(1'b0),
        .carry_in(1'b0), .max_en(max_en), .max_val(max_val), .mode(mode), .load(load),
        .load_val(load_val), .cnt_out(cnt_l), .carry_out(carry_l), .tc(tc_l), .done(done_l)
    );

    advanced_counter_n #(.WIDTH(4), .SYNC_STAGES(2)) u_hi (
        .clk(clk), .reset(reset_u), .inc(inc), .up_down_sel(1'b0), .carry_en(1'b1),
        .carry_in(carry_l), .max_en(1'b0), .max_val(4'd0), .mode(2'b00), .load(1'b0),
        .load_val(4'd0), .cnt_out(cnt_u), .carry_out(carry_u), .tc(tc_u), .done(done_u)
    );

    task automatic push(int unsigned c, bit up, bit cc, bit ca, bit ct, bit cd,
                        logic [3:0] cnt, logic car, logic tcv, logic dn, string nm);
        exp_t e;
        e.cyc = c; e.upper = up; e.c_cnt = cc; e.c_car = ca; e.c_tc = ct; e.c_dn = cd;
        e.cnt = cnt; e.car = car; e.tcv = tcv; e.dn = dn; e.name = nm;
        q.push_back(e);
    endtask

    task automatic cmp(string nm, string field, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s at cycle %0d: got %0d expected %0d", nm, field, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s stale expectation for cycle %0d", e.name, e.cyc);
                end else begin
                    if (e.c_cnt) cmp(e.name, "cnt", e.upper ? cnt_u : cnt_l, e.cnt);
                    if (e.c_car) cmp(e.name, "carry", e.upper ? carry_u : carry_l, e.car);
                    if (e.c_tc)  cmp(e.name, "tc", e.upper ? tc_u : tc_l, e.tcv);
                    if (e.c_dn)  cmp(e.name, "done", e.upper ? done_u : done_l, e.dn);
                end
            end
        end
    end

    // Called 1ns after a posedge; inc high for 3 cycles then low for 3.
    task automatic pulse(logic [3:0] lc, logic lcar, logic ltc, logic ldn,
                         bit cu, logic [3:0] uc, string nm);
        int unsigned c;
        c = cyc;
        push(c + 2, 1'b0, 0, 1, 0, 0, 4'd0, lcar, 1'b0, 1'b0, {nm, "_step"});
        push(c + 3, 1'b0, 1, 1, 1, 1, lc, 1'b0, ltc, ldn, nm);
        if (cu) push(c + 3, 1'b1, 1, 0, 0, 0, uc, 1'b0, 1'b0, 1'b0, {nm, "_upper"});
        inc = 1'b1;
        repeat (3) @(posedge clk);
        #1 inc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ld(logic [3:0] v, string nm);
        int unsigned c;
        c = cyc;
        load_val = v;
        load     = 1'b1;
        push(c + 1, 1'b0, 1, 1, 0, 1, v, 1'b0, 1'b0, 1'b0, nm);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned c;
        reset = 1'b1; reset_u = 1'b1; inc = 1'b0; ud = 1'b0; max_en = 1'b0;
        load = 1'b0; mode = 2'b00; max_val = 4'd0; load_val = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
        push(c, 1'b0, 1, 1, 1, 1, 4'd0, 1'b0, 1'b0, 1'b0, "reset_lo");
        push(c, 1'b1, 1, 1, 0, 1, 4'd0, 1'b0, 1'b0, 1'b0, "reset_hi");
        @(posedge clk);
        #1 reset = 1'b0;
        settle();

        // 1: free-running wrap up through 15 -> 0
        for (int i = 1; i <= 17; i++) begin
            pulse(4'(i % 16), i == 16, (i % 16) == 15, 1'b0, 1'b0, 4'd0, $sformatf("wrap%0d", i));
        end

        // 2: programmable limit, down wrap, lowered limit while above it
        max_en = 1'b1; max_val = 4'd5;
        ld(4'd0, "t2_ld0");
        ud = 1'b1;
        pulse(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "dn_wrap");
        pulse(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "dn_4");
        ld(4'd5, "t2_ld5a");
        ud = 1'b0; max_val = 4'd2;
        pulse(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "up_over");
        ld(4'd5, "t2_ld5b");
        ud = 1'b1;
        pulse(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "dn_clamp");
        pulse(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "dn_after");

        // 3: two-stage cascade
        ud = 1'b0; max_en = 1'b0;
        reset = 1'b1; reset_u = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; reset_u = 1'b0;
        settle();
        for (int i = 1; i <= 20; i++) begin
            pulse(4'(i % 16), i == 16, (i % 16) == 15, 1'b0, 1'b1, (i >= 16) ? 4'd1 : 4'd0,
                  $sformatf("casc%0d", i));
        end
        reset_u = 1'b1;

        // 4: one-shot
        max_en = 1'b1; max_val = 4'd3;
        ld(4'd0, "t4_ld0");
        mode = 2'b01;
        pulse(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "os1");
        pulse(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "os2");
        pulse(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "os3");
        pulse(4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "os4_term");
        pulse(4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, "os5_held");
        ld(4'd0, "os_reload");
        pulse(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "os_resume");

        // 5: auto-reload, then load colliding with a terminal step
        mode = 2'b10; max_en = 1'b0;
        ld(4'd15, "t5_ld15a");
        load_val = 4'd10;
        pulse(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "reload");
        ld(4'd15, "t5_ld15b");
        c = cyc;
        push(c + 2, 1'b0, 0, 1, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, "ld_evt_carry");
        push(c + 3, 1'b0, 1, 1, 0, 1, 4'd6, 1'b0, 1'b0, 1'b0, "ld_evt_cnt");
        inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 load = 1'b1; load_val = 4'd6;
        @(posedge clk);
        #1 load = 1'b0; inc = 1'b0; load_val = 4'd10;
        settle();
        pulse(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "reload_after");

        // 6: reset while inc is high must not create an event
        mode = 2'b00;
        ld(4'd7, "t6_ld7");
        c = cyc;
        push(c + 2, 1'b0, 1, 1, 0, 1, 4'd0, 1'b0, 1'b0, 1'b0, "rst_hi_a");
        push(c + 3, 1'b0, 1, 1, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, "rst_hi_b");
        push(c + 5, 1'b0, 1, 1, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0, "rst_hi_c");
        inc = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 inc = 1'b0;
        settle();
        pulse(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "fresh_edge");

        repeat (5) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
